// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side pointer, address and status controller for the async UART FIFO.
// Define FIFO_RD_SYNC_EN to add an internal SYNC_STAGES-deep synchroniser on wr_ptr_gr.
module fifo_rd_ctrl #(
    parameter int ADDR_W      = 4,
    parameter int AE_THRESH   = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic              rd_clk,
    input  logic              rd_reset_n,
    input  logic [ADDR_W:0]   wr_ptr_gr,
    input  logic              rd_en,
    input  logic              rd_err_clr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W:0]   rd_ptr_gr,
    output logic              rd_empty,
    output logic              rd_almost_empty,
    output logic [ADDR_W:0]   rd_level,
    output logic              rd_valid,
    output logic              rd_underflow
);

    localparam logic [ADDR_W:0] AE_LIM = (ADDR_W+1)'(AE_THRESH);

    if (SYNC_STAGES < 2) begin : g_sync_check
        $error("fifo_rd_ctrl: SYNC_STAGES must be at least 2");
    end
    if (AE_THRESH < 0 || AE_THRESH > (1 << ADDR_W)) begin : g_ae_check
        $error("fifo_rd_ctrl: AE_THRESH out of range");
    end

    function automatic logic [ADDR_W:0] bin2gray(input logic [ADDR_W:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
        logic [ADDR_W:0] b;
        b = g;
        for (int i = ADDR_W - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [ADDR_W:0] rd_ptr_bin;
    logic [ADDR_W:0] rd_ptr_bin_nxt;
    logic [ADDR_W:0] wsync;
    logic [ADDR_W:0] wbin;
    logic [ADDR_W:0] lvl_nxt;
    logic            acc;

`ifdef FIFO_RD_SYNC_EN
    // Write-pointer synchroniser chain; Gray coding keeps each hop single-bit.
    logic [ADDR_W:0] sync_q [SYNC_STAGES];

    always_ff @(posedge rd_clk) begin
        if (!rd_reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= wr_ptr_gr;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign wsync = sync_q[SYNC_STAGES-1];
`else
    assign wsync = wr_ptr_gr;
`endif

    // Status uses the post-accept pointer so a read releases its entry at the same edge.
    assign acc            = rd_en & ~rd_empty;
    assign rd_ptr_bin_nxt = rd_ptr_bin + {{ADDR_W{1'b0}}, acc};
    assign wbin           = gray2bin(wsync);
    assign lvl_nxt        = wbin - rd_ptr_bin_nxt;
    assign rd_addr        = rd_ptr_bin[ADDR_W-1:0];

    always_ff @(posedge rd_clk) begin
        if (!rd_reset_n) begin
            rd_ptr_bin      <= '0;
            rd_ptr_gr       <= '0;
            rd_empty        <= 1'b1;
            rd_almost_empty <= 1'b1;
            rd_level        <= '0;
            rd_valid        <= 1'b0;
            rd_underflow    <= 1'b0;
        end else begin
            rd_ptr_bin      <= rd_ptr_bin_nxt;
            rd_ptr_gr       <= bin2gray(rd_ptr_bin_nxt);
            rd_empty        <= (lvl_nxt == '0);
            rd_almost_empty <= (lvl_nxt <= AE_LIM);
            rd_level        <= lvl_nxt;
            rd_valid        <= acc;
            if (rd_en && rd_empty) begin
                rd_underflow <= 1'b1;
            end else if (rd_err_clr) begin
                rd_underflow <= 1'b0;
            end
        end
    end

endmodule
